// File: rtl/ebrick_cpu_core_if.sv
// UMI request/response channel pair for the ebrick core data port.
// master drives requests and consumes responses; slave is the memory endpoint.
interface ebrick_cpu_core_if #(
    parameter int UW = 256
);
    logic          in_valid;
    logic [UW-1:0] in_packet;
    logic          in_ready;
    logic          out_valid;
    logic [UW-1:0] out_packet;
    logic          out_ready;

    modport master (
        output in_valid, in_packet, out_ready,
        input  in_ready, out_valid, out_packet
    );

    modport slave (
        input  in_valid, in_packet, out_ready,
        output in_ready, out_valid, out_packet
    );
endinterface

// File: rtl/ebrick_cpu_core.sv
// Ebrick core-side UMI memory endpoint: clears local RAM after reset, then serves READ/WRITE on umi1.
// Define EBRICK_CPU_CORE_WRACK_EN to enable acknowledged writes (opcode 04 -> 05 response).
module ebrick_cpu_core #(
    parameter int          UW       = 256,
    parameter int          DEPTH    = 256,
    parameter logic [31:0] BASEADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             error_fatal,
    output logic             initdone,
    ebrick_cpu_core_if.slave umi1
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] RANGE = 33'(DEPTH) << 3;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_RDRESP = 8'h03;
`ifdef EBRICK_CPU_CORE_WRACK_EN
    localparam logic [7:0] OP_WRACKREQ = 8'h04;
    localparam logic [7:0] OP_WRACK    = 8'h05;
`endif

    // Fixed 256b UMI layout; UW is carried for the interface and must be 256.
    typedef struct packed {
        logic [95:0] rsvd;
        logic [63:0] data;
        logic [31:0] srcaddr;
        logic [31:0] dstaddr;
        logic [19:0] zero;
        logic [3:0]  size;
        logic [7:0]  opcode;
    } umi_pkt_t;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          state_q, state_d;
    logic            clr_we;
    logic [AW-1:0]   clr_ptr;
    logic [63:0]     mem [DEPTH];

    umi_pkt_t        req, resp_d, resp_q;
    logic            out_valid_q;

    logic [2:0]      off;
    logic [31:0]     offs;
    logic [AW-1:0]   idx;
    logic [2:0]      align_mask;
    logic [7:0]      size_be;
    logic [63:0]     size_m64;
    logic [7:0]      be;
    logic [63:0]     wdata, rsh, rdata;
    logic            is_wr, is_rd, is_wrack;
    logic            legal, accept, do_write, do_resp;
    logic            unused_bits;

    // ---------------- init FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_CLEAR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_we = ~rst;
                if (!rst && clr_ptr == AW'(DEPTH - 1)) state_d = S_RUN;
            end
            S_RUN: ;
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         clr_ptr <= '0;
        else if (clr_we) clr_ptr <= clr_ptr + 1'b1;
    end

    assign initdone = (state_q == S_RUN);

    // ---------------- request decode ----------------
    assign req  = umi_pkt_t'(umi1.in_packet);
    assign off  = req.dstaddr[2:0];
    assign offs = req.dstaddr - BASEADDR;
    assign idx  = offs[AW+2:3];

    always_comb begin
        align_mask = 3'b000;
        size_be    = 8'h01;
        size_m64   = 64'hFF;
        case (req.size[1:0])
            2'd0: begin align_mask = 3'b000; size_be = 8'h01; size_m64 = 64'h0000_0000_0000_00FF; end
            2'd1: begin align_mask = 3'b001; size_be = 8'h03; size_m64 = 64'h0000_0000_0000_FFFF; end
            2'd2: begin align_mask = 3'b011; size_be = 8'h0F; size_m64 = 64'h0000_0000_FFFF_FFFF; end
            default: begin align_mask = 3'b111; size_be = 8'hFF; size_m64 = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
    end

    assign is_wr = (req.opcode == OP_WRITE);
    assign is_rd = (req.opcode == OP_READ);
`ifdef EBRICK_CPU_CORE_WRACK_EN
    assign is_wrack = (req.opcode == OP_WRACKREQ);
`else
    assign is_wrack = 1'b0;
`endif

    assign legal = (is_wr | is_rd | is_wrack)
                 & (req.size <= 4'd3)
                 & ((off & align_mask) == 3'b000)
                 & (req.dstaddr >= BASEADDR)
                 & ({1'b0, offs} < RANGE);

    assign umi1.in_ready = initdone & (~out_valid_q | umi1.out_ready);
    assign accept        = umi1.in_valid & umi1.in_ready;
    assign do_write      = accept & legal & (is_wr | is_wrack);
    assign do_resp       = accept & legal & (is_rd | is_wrack);

    // ---------------- RAM ----------------
    assign be    = size_be << off;
    assign wdata = req.data << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // Asynchronous read so a read right after a write to the same word sees the new bytes.
    assign rsh   = mem[idx] >> {off, 3'b000};
    assign rdata = rsh & size_m64;

    // ---------------- response ----------------
    always_comb begin
        resp_d         = '0;
        resp_d.opcode  = OP_RDRESP;
        resp_d.size    = req.size;
        resp_d.dstaddr = req.srcaddr;
        resp_d.srcaddr = req.dstaddr;
        resp_d.data    = rdata;
`ifdef EBRICK_CPU_CORE_WRACK_EN
        if (is_wrack) begin
            resp_d.opcode = OP_WRACK;
            resp_d.data   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            resp_q      <= '0;
            error_fatal <= 1'b0;
        end else begin
            if (do_resp) begin
                out_valid_q <= 1'b1;
                resp_q      <= resp_d;
            end else if (umi1.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && !legal) error_fatal <= 1'b1;
        end
    end

    assign umi1.out_valid  = out_valid_q;
    assign umi1.out_packet = UW'(resp_q);

    assign unused_bits = ^{req.rsvd, req.zero};
endmodule

// File: tb/tb_ebrick_cpu_core.sv
// Directed + randomized bench for ebrick_cpu_core; byte-array memory model and expected-response queue.
module tb_ebrick_cpu_core;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;
`ifdef EBRICK_CPU_CORE_WRACK_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic error_fatal, initdone;

    ebrick_cpu_core_if #(.UW(256)) umi1();

    ebrick_cpu_core #(.UW(256), .DEPTH(DEPTH), .BASEADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .error_fatal (error_fatal),
        .initdone    (initdone),
        .umi1        (umi1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0]   mbytes [DEPTH*8];
    logic         m_err = 1'b0;
    logic [255:0] expq [$];
    int           resp_cyc [$];
    logic [255:0] last_pkt = '0;
    bit           rnd_bp = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [7:0] op, input logic [3:0] sz,
                                        input logic [31:0] dst, input logic [31:0] src,
                                        input logic [63:0] d);
        return {96'b0, d, src, dst, 20'b0, sz, op};
    endfunction

    // Memory endpoint behaviour as bytes: legal writes update bytes, legal reads queue a response.
    task automatic model_apply(input logic [255:0] p);
        logic [7:0]  op  = p[7:0];
        logic [3:0]  sz  = p[11:8];
        logic [31:0] dst = p[63:32];
        logic [31:0] src = p[95:64];
        logic [63:0] d   = p[159:96];
        logic [63:0] rd  = '0;
        longint      nb, a;
        bit          ok;
        ok = (op == 8'h01 || op == 8'h02 || (WR_EN && op == 8'h04)) && sz <= 3;
        nb = 1 << sz[1:0];
        a  = longint'(dst) - longint'(BASE);
        ok = ok && (dst % nb == 0) && a >= 0 && a < DEPTH*8;
        if (!ok) begin
            m_err = 1'b1;
            return;
        end
        if (op == 8'h01 || op == 8'h04)
            for (int i = 0; i < nb; i++) mbytes[a+i] = d[8*i +: 8];
        if (op == 8'h02) begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = mbytes[a+i];
            expq.push_back(mk(8'h03, sz, src, dst, rd));
        end
        if (op == 8'h04) expq.push_back(mk(8'h05, sz, src, dst, 64'h0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH*8; i++) mbytes[i] = 8'h00;
        m_err = 1'b0;
        expq.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 of the accept edge.
    task automatic send(input logic [255:0] p);
        int n = 0;
        umi1.in_valid  = 1'b1;
        umi1.in_packet = p;
        @(negedge clk);
        while (!umi1.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!umi1.in_ready) begin
            check("send_timeout", umi1.in_ready, 1'b1);
            umi1.in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        umi1.in_valid = 1'b0;
        model_apply(p);
    endtask

    task automatic drain();
        int n = 0;
        umi1.out_ready = 1'b1;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", 32'(expq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int  n0 = 0;
        bit  rdy_seen = 1'b0;
        while (!initdone && n0 < 1000) begin
            if (umi1.in_ready) rdy_seen = 1'b1;
            n0++;
            @(posedge clk); #1;
        end
        check("init_cycles", 32'(n0), 32'd256);
        check("in_ready_during_init", rdy_seen, 1'b0);
        check("in_ready_after_init", umi1.in_ready, 1'b1);
    endtask

    always @(posedge clk) cyc++;

    // Response monitor: a transfer happens at the posedge following a negedge where valid&ready.
    always @(negedge clk) begin
        if (!rst && umi1.out_valid && umi1.out_ready) begin
            check("resp_expected", expq.size() != 0, 1'b1);
            if (expq.size() != 0) check("resp_pkt", umi1.out_packet, expq.pop_front());
            last_pkt = umi1.out_packet;
            resp_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_bp) umi1.out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        logic [255:0] hold_exp;
        int           n0, c0;
        umi1.in_valid  = 1'b0;
        umi1.in_packet = '0;
        umi1.out_ready = 1'b1;
        model_reset();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_error_fatal", error_fatal, 1'b0);
        check("rst_initdone", initdone, 1'b0);
        check("rst_out_valid", umi1.out_valid, 1'b0);
        check("rst_out_packet", umi1.out_packet, 256'h0);
        check("rst_in_ready", umi1.in_ready, 1'b0);

        rst = 1'b0;
        wait_init();

        send(mk(8'h02, 4'd3, 32'h0, 32'h100, 64'h0));
        drain();
        check("rd0_data", last_pkt[159:96], 64'h0);

        send(mk(8'h01, 4'd3, 32'h10, 32'h0, 64'h1122334455667788));
        send(mk(8'h02, 4'd1, 32'h12, 32'hABCD, 64'h0));
        drain();
        check("rd12_opcode", last_pkt[7:0], 8'h03);
        check("rd12_data", last_pkt[159:96], 64'h5566);
        check("rd12_dst", last_pkt[63:32], 32'hABCD);
        check("rd12_src", last_pkt[95:64], 32'h12);

        // backpressure hold
        umi1.out_ready = 1'b0;
        c0 = resp_cyc.size();
        send(mk(8'h02, 4'd3, 32'h8, 32'h55, 64'h0));
        hold_exp = expq[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", umi1.out_valid, 1'b1);
            check("hold_pkt", umi1.out_packet, hold_exp);
            check("hold_in_ready", umi1.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        drain();
        check("hold_one_resp", 32'(resp_cyc.size() - c0), 32'd1);
        check("hold_valid_after", umi1.out_valid, 1'b0);

        // streaming reads
        c0 = resp_cyc.size();
        n0 = cyc;
        for (int i = 0; i < 8; i++) send(mk(8'h02, 4'd3, 32'(8*i), 32'(i), 64'h0));
        check("stream_accept_cycles", 32'(cyc - n0), 32'd8);
        drain();
        check("stream_count", 32'(resp_cyc.size() - c0), 32'd8);
        check("stream_span", 32'(resp_cyc[c0+7] - resp_cyc[c0]), 32'd7);

        // acknowledged write
        check("err_before_wrack", error_fatal, 1'b0);
        send(mk(8'h04, 4'd2, 32'h20, 32'h77, 64'hDEADBEEF));
        drain();
        check("wrack_err", error_fatal, !WR_EN);
        if (WR_EN) check("wrack_opcode", last_pkt[7:0], 8'h05);
        send(mk(8'h02, 4'd2, 32'h20, 32'h78, 64'h0));
        drain();
        check("wrack_readback", last_pkt[159:96], WR_EN ? 64'hDEADBEEF : 64'h0);

        // reset mid-operation with a response pending
        umi1.out_ready = 1'b0;
        send(mk(8'h02, 4'd3, 32'h10, 32'h1, 64'h0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", umi1.out_valid, 1'b0);
        check("midrst_initdone", initdone, 1'b0);
        check("midrst_error", error_fatal, 1'b0);
        model_reset();
        umi1.out_ready = 1'b1;
        rst = 1'b0;
        wait_init();
        send(mk(8'h02, 4'd3, 32'h10, 32'h2, 64'h0));
        drain();
        check("midrst_cleared", last_pkt[159:96], 64'h0);

        // illegal traffic
        c0 = resp_cyc.size();
        send(mk(8'h02, 4'd2, 32'h801, 32'h3, 64'h0));
        drain();
        check("illegal_no_resp", 32'(resp_cyc.size() - c0), 32'd0);
        check("illegal_err", error_fatal, 1'b1);
        send(mk(8'h02, 4'd3, 32'h10, 32'h4, 64'h0));
        drain();
        check("post_err_resp", 32'(resp_cyc.size() - c0), 32'd1);
        check("post_err_sticky", error_fatal, 1'b1);

        // randomized legal/illegal mix under random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [255:0] p;
            logic [3:0]   sz = 4'($urandom_range(0, 3));
            logic [7:0]   op = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02;
            logic [31:0]  a  = 32'($urandom_range(0, 31) * 8) + 32'($urandom_range(0, 7) & ~((1 << sz) - 1));
            case ($urandom_range(0, 19))
                0: a = a + 32'(DEPTH*8);
                1: op = 8'h07;
                2: sz = 4'($urandom_range(4, 15));
                default: ;
            endcase
            p = mk(op, sz, BASE + a, $urandom, {$urandom, $urandom});
            p[255:160] = {$urandom, $urandom, $urandom};
            send(p);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_bp = 1'b0;
        @(posedge clk); #1;
        drain();
        check("final_err", error_fatal, m_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
